// File: rtl/sram_pkg.sv
// Purpose : shared types and helpers for the byte-wide SRAM access controller.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, chip-count constant, lane select and
// active-low chip-enable decode helpers.
package sram_pkg;

   // Four 512Kx16 chips; address bits [20:19] pick one of them.
   localparam int N_CHIPS = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WSETUP = 3'd1,
      ST_WPULSE = 3'd2,
      ST_WHOLD  = 3'd3,
      ST_RWAIT  = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   // Odd chips (1, 3) carry the upper byte lane, even chips the lower one.
   function automatic logic lane_of(input logic [20:0] addr);
      return addr[19];
   endfunction

   // One-cold chip enable for the selected chip.
   function automatic logic [N_CHIPS-1:0] ce_decode(input logic [1:0] sel);
      return ~(N_CHIPS'(1) << sel);
   endfunction

endpackage

// File: rtl/sram_byte_ctrl.sv
// Purpose : byte-wide access controller in front of four 512Kx16 SRAM chips.
// Latency : write ack at N+3+WE_PULSE, read ack at N+1+RD_WAIT (N = req sampled in IDLE).
// Backpressure: busy is high outside IDLE; req is only sampled in IDLE, so holding it waits.
//
// Ports:
//   clk_100, reset_n            clock, asynchronous active-low reset
//   req, we, addr, wdata        core request (level), latched only in IDLE
//   rdata, ack, busy            read byte, one-cycle completion pulse, busy flag
//   sram_a, sram_d_out          SRAM word address, write data (byte on both lanes)
//   sram_d_in                   SRAM data pins, read path
//   sram_d_oe_hi/_lo            pad drive enables for D[15:8] / D[7:0]
//   sram_ce_n, sram_oe_n,
//   sram_we_n                   active-low SRAM strobes
module sram_byte_ctrl
   import sram_pkg::*;
#(
   parameter int WE_PULSE = 2,
   parameter int RD_WAIT  = 2
) (
   input  logic                clk_100,
   input  logic                reset_n,
   input  logic                req,
   input  logic                we,
   input  logic [20:0]         addr,
   input  logic [7:0]          wdata,
   output logic [7:0]          rdata,
   output logic                ack,
   output logic                busy,
   output logic [18:0]         sram_a,
   output logic [15:0]         sram_d_out,
   input  logic [15:0]         sram_d_in,
   output logic                sram_d_oe_hi,
   output logic                sram_d_oe_lo,
   output logic [N_CHIPS-1:0]  sram_ce_n,
   output logic                sram_oe_n,
   output logic                sram_we_n
);

   localparam int CNT_MAX = (WE_PULSE > RD_WAIT) ? WE_PULSE : RD_WAIT;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   // FSM, wait-state counter and latched request
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [20:0]        addr_q,  addr_d;
   logic [7:0]         wdata_q, wdata_d;

   // Registered outputs
   logic [7:0]         rdata_q, rdata_d;
   logic               ack_q,   ack_d;
   logic [N_CHIPS-1:0] ce_n_q,  ce_n_d;
   logic               oe_n_q,  oe_n_d;
   logic               we_n_q,  we_n_d;
   logic               doe_hi_q, doe_hi_d;
   logic               doe_lo_q, doe_lo_d;

   logic               wr_drive;

   // Next-state logic. The counter is loaded on entry to a timed state
   // with (length-1) and counts down to zero, so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d  = addr;
               wdata_d = wdata;
               if (we) begin
                  state_d = ST_WSETUP;
               end else begin
                  state_d = ST_RWAIT;
                  cnt_d   = CNT_W'(RD_WAIT - 1);
               end
            end
         end
         ST_WSETUP: begin
            state_d = ST_WPULSE;
            cnt_d   = CNT_W'(WE_PULSE - 1);
         end
         ST_WPULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_WHOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WHOLD: begin
            state_d = ST_DONE;
         end
         ST_RWAIT: begin
            if (cnt_q == '0) begin
               // Capture on the edge that ends the last wait cycle.
               state_d = ST_DONE;
               rdata_d = lane_of(addr_q) ? sram_d_in[15:8] : sram_d_in[7:0];
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Strobes are decoded from the *next* state and registered, so every
   // SRAM-side pin is a flop output and cannot glitch.
   always_comb begin
      wr_drive = (state_d == ST_WSETUP) || (state_d == ST_WPULSE) ||
                 (state_d == ST_WHOLD);

      ce_n_d   = {N_CHIPS{1'b1}};
      if (wr_drive || (state_d == ST_RWAIT)) begin
         ce_n_d = ce_decode(addr_d[20:19]);
      end

      we_n_d   = (state_d != ST_WPULSE);
      oe_n_d   = (state_d != ST_RWAIT);
      // Data stays driven through WHOLD, giving one cycle of hold after WE_n rises.
      doe_hi_d = wr_drive &  lane_of(addr_d);
      doe_lo_d = wr_drive & ~lane_of(addr_d);
      ack_d    = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         ack_q    <= 1'b0;
         ce_n_q   <= {N_CHIPS{1'b1}};
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         doe_hi_q <= 1'b0;
         doe_lo_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
         ce_n_q   <= ce_n_d;
         oe_n_q   <= oe_n_d;
         we_n_q   <= we_n_d;
         doe_hi_q <= doe_hi_d;
         doe_lo_q <= doe_lo_d;
      end
   end

   assign rdata        = rdata_q;
   assign ack          = ack_q;
   assign busy         = (state_q != ST_IDLE);
   assign sram_a       = addr_q[18:0];
   assign sram_d_out   = {wdata_q, wdata_q};
   assign sram_d_oe_hi = doe_hi_q;
   assign sram_d_oe_lo = doe_lo_q;
   assign sram_ce_n    = ce_n_q;
   assign sram_oe_n    = oe_n_q;
   assign sram_we_n    = we_n_q;

endmodule

// File: tb/tb_sram_byte_ctrl.sv
// Purpose : directed bench for sram_byte_ctrl (default and WE_PULSE=1/RD_WAIT=4).
// Latency : n/a.
// Backpressure: n/a.
module tb_sram_byte_ctrl;

   logic        clk_100 = 1'b0;
   logic        reset_n;
   logic        req, req2, we;
   logic [20:0] addr;
   logic [7:0]  wdata;
   logic [15:0] sram_d_in;

   logic [7:0]  rdata, rdata2;
   logic        ack, ack2, busy, busy2;
   logic [18:0] sram_a, sram_a2;
   logic [15:0] d_out, d_out2;
   logic        oe_hi, oe_lo, oe_hi2, oe_lo2;
   logic [3:0]  ce_n, ce_n2;
   logic        oe_n, oe_n2, we_n, we_n2;

   int checks = 0;
   int errors = 0;
   int ack_seen;

   always #5 clk_100 = ~clk_100;

   sram_byte_ctrl u_dut (
      .clk_100(clk_100), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .sram_a(sram_a),
      .sram_d_out(d_out), .sram_d_in(sram_d_in), .sram_d_oe_hi(oe_hi),
      .sram_d_oe_lo(oe_lo), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
   );

   sram_byte_ctrl #(.WE_PULSE(1), .RD_WAIT(4)) u_sw (
      .clk_100(clk_100), .reset_n(reset_n), .req(req2), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata2), .ack(ack2), .busy(busy2), .sram_a(sram_a2),
      .sram_d_out(d_out2), .sram_d_in(sram_d_in), .sram_d_oe_hi(oe_hi2),
      .sram_d_oe_lo(oe_lo2), .sram_ce_n(ce_n2), .sram_oe_n(oe_n2), .sram_we_n(we_n2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_100);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      req       = 1'b0;
      req2      = 1'b0;
      we        = 1'b0;
      addr      = '0;
      wdata     = '0;
      sram_d_in = '0;
      tick();
      tick();
      reset_n = 1'b1;

      // Reset state
      chk("rst_ce",    ce_n,  4'hF);
      chk("rst_we",    we_n,  1);
      chk("rst_oe",    oe_n,  1);
      chk("rst_doe",   {oe_hi, oe_lo}, 0);
      chk("rst_ack",   ack,   0);
      chk("rst_busy",  busy,  0);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_a",     sram_a, 0);
      chk("rst_dout",  d_out, 0);
      chk("rst_ce2",   ce_n2, 4'hF);

      // Write A5 to 0x000010 (chip 0, lower lane); inputs scrambled while busy
      req = 1'b1; we = 1'b1; addr = 21'h000010; wdata = 8'hA5;   // cycle N
      tick();                                                      // N+1 WSETUP
      req = 1'b0; we = 1'b0; addr = 21'h1FFFFF; wdata = 8'h00;
      chk("wr_setup_ce",  ce_n, 4'b1110);
      chk("wr_setup_doe", {oe_hi, oe_lo}, 2'b01);
      chk("wr_setup_we",  we_n, 1);
      chk("wr_setup_oe",  oe_n, 1);
      chk("wr_setup_a",   sram_a, 19'h00010);
      chk("wr_setup_d",   d_out, 16'hA5A5);
      chk("wr_setup_busy", busy, 1);
      tick();                                                      // N+2
      chk("wr_pulse1_we", we_n, 0);
      chk("wr_pulse1_d",  d_out, 16'hA5A5);
      tick();                                                      // N+3
      chk("wr_pulse2_we", we_n, 0);
      chk("wr_pulse2_a",  sram_a, 19'h00010);
      tick();                                                      // N+4 WHOLD
      chk("wr_hold_we",   we_n, 1);
      chk("wr_hold_doe",  {oe_hi, oe_lo}, 2'b01);
      chk("wr_hold_ack",  ack, 0);
      tick();                                                      // N+5 DONE
      chk("wr_done_ack",  ack, 1);
      chk("wr_done_doe",  {oe_hi, oe_lo}, 2'b00);
      chk("wr_done_we",   we_n, 1);
      tick();                                                      // N+6
      chk("wr_idle_ack",  ack, 0);
      chk("wr_idle_busy", busy, 0);
      chk("wr_idle_ce",   ce_n, 4'hF);

      // Read 0x180020 (chip 3, upper lane)
      sram_d_in = 16'h3C00;
      req = 1'b1; we = 1'b0; addr = 21'h180020;                   // cycle N
      tick();                                                      // N+1
      req = 1'b0;
      chk("rd_ce",   ce_n, 4'b0111);
      chk("rd_a",    sram_a, 19'h00020);
      chk("rd_oe1",  oe_n, 0);
      chk("rd_doe",  {oe_hi, oe_lo}, 2'b00);
      chk("rd_we",   we_n, 1);
      tick();                                                      // N+2
      chk("rd_oe2",  oe_n, 0);
      chk("rd_ack_early", ack, 0);
      tick();                                                      // N+3
      chk("rd_ack",   ack, 1);
      chk("rd_rdata", rdata, 8'h3C);
      chk("rd_oe_off", oe_n, 1);
      sram_d_in = 16'hFFFF;
      tick();
      chk("rd_hold_rdata", rdata, 8'h3C);

      // Back-to-back: write then read with req held through the write ack
      req = 1'b1; we = 1'b1; addr = 21'h080001; wdata = 8'h5E;    // cycle N
      sram_d_in = 16'h9911;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("b2b_no_overlap", {we_n, oe_n} != 2'b00, 1);
         if (k == 1) chk("b2b_wr_doe", {oe_hi, oe_lo}, 2'b10);
         if (k == 5) begin
            chk("b2b_wr_ack", ack, 1);
            we = 1'b0; addr = 21'h000040;
         end
         if (k == 6) begin
            chk("b2b_gap_busy", busy, 0);
            chk("b2b_gap_oe", oe_n, 1);
         end
         if (k == 7) begin
            chk("b2b_rd_start", oe_n, 0);
            chk("b2b_rd_ce", ce_n, 4'b1110);
         end
         if (k == 9) begin
            chk("b2b_rd_ack", ack, 1);
            chk("b2b_rd_data", rdata, 8'h11);
            req = 1'b0;
         end
         if (k == 10) chk("b2b_end_busy", busy, 0);
      end

      // Reset in the middle of WPULSE
      req = 1'b1; we = 1'b1; addr = 21'h100002; wdata = 8'h77;    // cycle N
      tick();
      req = 1'b0;
      tick();                                                      // N+2 WPULSE
      chk("ar_pre_we", we_n, 0);
      #3;
      reset_n = 1'b0;
      #1;
      chk("ar_we",    we_n, 1);
      chk("ar_ce",    ce_n, 4'hF);
      chk("ar_doe",   {oe_hi, oe_lo}, 2'b00);
      chk("ar_busy",  busy, 0);
      chk("ar_rdata", rdata, 8'h00);
      tick();
      reset_n = 1'b1;
      ack_seen = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (ack) ack_seen++;
      end
      chk("ar_no_ack", ack_seen, 0);
      chk("ar_idle", busy, 0);

      // Parameter sweep instance: WE_PULSE=1, RD_WAIT=4
      req2 = 1'b1; we = 1'b1; addr = 21'h080004; wdata = 8'hC9;   // cycle N
      tick();                                                      // N+1
      req2 = 1'b0;
      chk("sw_wr_setup_we", we_n2, 1);
      chk("sw_wr_ce", ce_n2, 4'b1101);
      tick();                                                      // N+2
      chk("sw_wr_pulse_we", we_n2, 0);
      tick();                                                      // N+3
      chk("sw_wr_hold_we", we_n2, 1);
      chk("sw_wr_hold_ack", ack2, 0);
      tick();                                                      // N+4
      chk("sw_wr_ack", ack2, 1);
      tick();
      chk("sw_wr_ack_off", ack2, 0);

      sram_d_in = 16'h5AC3;
      req2 = 1'b1; we = 1'b0;                                      // cycle N
      for (int k = 1; k <= 5; k++) begin
         tick();
         req2 = 1'b0;
         if (k <= 4) begin
            chk("sw_rd_oe", oe_n2, 0);
            chk("sw_rd_noack", ack2, 0);
         end else begin
            chk("sw_rd_ack", ack2, 1);
            chk("sw_rd_data", rdata2, 8'h5A);
            chk("sw_rd_oe_off", oe_n2, 1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
